sa_aw_order_arbiter: RTL and testbench

- Per-slave write-address arbiter, one instance per slave port.
- Selects one AW request among MST_AMT dispatchers using round-robin and drives the slave AW channel through a single output register stage.
- In the same cycle it accepts a request, it pushes {master id, AxLEN} into the WDATA channel's ordering FIFO. This keeps the WDATA beat order identical to the AW order seen by the slave.
- Stops accepting while the WDATA ordering FIFO reports full.

---
 rtl/sa_aw_order_arbiter.sv | 113 +++++++++++
 tb/tb_sa_aw_order_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sa_aw_order_arbiter.sv
// Per-slave AW arbiter: round-robin selection among dispatchers, one output register stage,
// and a push of {master index, AxLEN} into the WDATA ordering FIFO for every accepted address.
module sa_aw_order_arbiter #(
    parameter int MST_AMT          = 3,
    parameter int MST_ID_W         = $clog2(MST_AMT),
    parameter int TRANS_MST_ID_W   = 5,
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 3
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESET_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_AWID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]          dsp_AWADDR_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    dsp_AWLEN_i,
    input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
    input  logic [MST_AMT-1:0]                     dsp_slv_sel_i,
    output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
    output logic [MST_ID_W+TRANS_MST_ID_W-1:0]     s_AWID_o,
    output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
    output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
    output logic                                   s_AWVALID_o,
    input  logic                                   s_AWREADY_i,
    input  logic                                   AW_stall_i,
    output logic [MST_ID_W-1:0]                    AW_mst_id_o,
    output logic [TRANS_DATA_LEN_W-1:0]            AW_AxLEN_o,
    output logic                                   AW_fifo_order_wr_en_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                        state_r;
    logic [MST_ID_W-1:0]           rr_ptr_r;
    logic [MST_AMT-1:0]            req_s;
    logic [MST_ID_W-1:0]           winner_s;
    logic [MST_ID_W-1:0]           next_ptr_s;
    logic                          found_s;
    logic                          load_en_s;
    logic [TRANS_MST_ID_W-1:0]     sel_id_s;
    logic [ADDR_WIDTH-1:0]         sel_addr_s;
    logic [TRANS_DATA_LEN_W-1:0]   sel_len_s;

    assign req_s       = dsp_AWVALID_i & dsp_slv_sel_i;
    assign s_AWVALID_o = (state_r == BUSY);

    // Reset also gates acceptance so no master sees AWREADY while the block is being cleared.
    assign load_en_s = found_s & ~AW_stall_i & (~s_AWVALID_o | s_AWREADY_i) & ~ARESET_i;

    // Round-robin scan starting at rr_ptr_r; the first requester found wins and its payload is muxed out.
    always_comb begin
        int idx_v;
        idx_v      = 0;
        winner_s   = '0;
        found_s    = 1'b0;
        sel_id_s   = '0;
        sel_addr_s = '0;
        sel_len_s  = '0;
        for (int k = 0; k < MST_AMT; k++) begin
            idx_v = (int'(rr_ptr_r) + k) % MST_AMT;
            if (!found_s && req_s[idx_v]) begin
                found_s    = 1'b1;
                winner_s   = MST_ID_W'(idx_v);
                sel_id_s   = dsp_AWID_i[idx_v*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                sel_addr_s = dsp_AWADDR_i[idx_v*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len_s  = dsp_AWLEN_i[idx_v*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
            end else begin
            end
        end
    end

    // Pointer advances past the winner and wraps at the last master.
    always_comb begin
        if (winner_s == MST_ID_W'(MST_AMT - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = winner_s + MST_ID_W'(1);
        end
    end

    // Master AWREADY and the ordering-FIFO push are the same event.
    always_comb begin
        dsp_AWREADY_o = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            dsp_AWREADY_o[i] = load_en_s & (winner_s == MST_ID_W'(i));
        end
    end

    assign AW_fifo_order_wr_en_o = load_en_s;
    assign AW_mst_id_o           = winner_s;
    assign AW_AxLEN_o            = sel_len_s;

    // IDLE/BUSY state with the slave payload register; payload only changes on a load.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            s_AWID_o   <= '0;
            s_AWADDR_o <= '0;
            s_AWLEN_o  <= '0;
        end else if (load_en_s) begin
            state_r    <= BUSY;
            rr_ptr_r   <= next_ptr_s;
            s_AWID_o   <= {winner_s, sel_id_s};
            s_AWADDR_o <= sel_addr_s;
            s_AWLEN_o  <= sel_len_s;
        end else if ((state_r == BUSY) && s_AWREADY_i) begin
            state_r    <= IDLE;
        end
    end

endmodule

// File: tb/tb_sa_aw_order_arbiter.sv
// Directed bench for sa_aw_order_arbiter: reset, single grant, stall, slave select,
// round-robin fairness, slave backpressure and reset in the middle of a transfer.
module tb_sa_aw_order_arbiter;

    logic        ACLK_i = 1'b0;
    logic        ARESET_i;
    logic [14:0] dsp_AWID_i;
    logic [95:0] dsp_AWADDR_i;
    logic [8:0]  dsp_AWLEN_i;
    logic [2:0]  dsp_AWVALID_i;
    logic [2:0]  dsp_slv_sel_i;
    logic [2:0]  dsp_AWREADY_o;
    logic [6:0]  s_AWID_o;
    logic [31:0] s_AWADDR_o;
    logic [2:0]  s_AWLEN_o;
    logic        s_AWVALID_o;
    logic        s_AWREADY_i;
    logic        AW_stall_i;
    logic [1:0]  AW_mst_id_o;
    logic [2:0]  AW_AxLEN_o;
    logic        AW_fifo_order_wr_en_o;

    int checks   = 0;
    int failures = 0;

    sa_aw_order_arbiter dut (
        .ACLK_i                (ACLK_i),
        .ARESET_i              (ARESET_i),
        .dsp_AWID_i            (dsp_AWID_i),
        .dsp_AWADDR_i          (dsp_AWADDR_i),
        .dsp_AWLEN_i           (dsp_AWLEN_i),
        .dsp_AWVALID_i         (dsp_AWVALID_i),
        .dsp_slv_sel_i         (dsp_slv_sel_i),
        .dsp_AWREADY_o         (dsp_AWREADY_o),
        .s_AWID_o              (s_AWID_o),
        .s_AWADDR_o            (s_AWADDR_o),
        .s_AWLEN_o             (s_AWLEN_o),
        .s_AWVALID_o           (s_AWVALID_o),
        .s_AWREADY_i           (s_AWREADY_i),
        .AW_stall_i            (AW_stall_i),
        .AW_mst_id_o           (AW_mst_id_o),
        .AW_AxLEN_o            (AW_AxLEN_o),
        .AW_fifo_order_wr_en_o (AW_fifo_order_wr_en_o)
    );

    always #5 ACLK_i = ~ACLK_i;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK_i);
        #1;
    endtask

    task automatic set_m(input int i, input logic v, input logic sel,
                         input logic [4:0] id, input logic [31:0] addr, input logic [2:0] len);
        dsp_AWVALID_i[i]         = v;
        dsp_slv_sel_i[i]         = sel;
        dsp_AWID_i[i*5 +: 5]     = id;
        dsp_AWADDR_i[i*32 +: 32] = addr;
        dsp_AWLEN_i[i*3 +: 3]    = len;
    endtask

    task automatic clr_all();
        dsp_AWVALID_i = 3'b000;
        dsp_slv_sel_i = 3'b000;
        dsp_AWID_i    = 15'd0;
        dsp_AWADDR_i  = 96'd0;
        dsp_AWLEN_i   = 9'd0;
    endtask

    initial begin
        ARESET_i    = 1'b1;
        s_AWREADY_i = 1'b0;
        AW_stall_i  = 1'b0;
        clr_all();
        tick();
        tick();
        chk("rst_valid", {39'd0, s_AWVALID_o}, 40'd0);
        chk("rst_awid", {33'd0, s_AWID_o}, 40'd0);
        chk("rst_addr", {8'd0, s_AWADDR_o}, 40'd0);
        chk("rst_len", {37'd0, s_AWLEN_o}, 40'd0);
        // A request under reset must not be acknowledged.
        set_m(1, 1'b1, 1'b1, 5'd5, 32'h100, 3'd3);
        #1;
        chk("rst_awready", {37'd0, dsp_AWREADY_o}, 40'd0);
        chk("rst_wren", {39'd0, AW_fifo_order_wr_en_o}, 40'd0);
        chk("rst_mstid_known", {39'd0, $isunknown(AW_mst_id_o)}, 40'd0);

        // Single request from master 1.
        ARESET_i = 1'b0;
        #1;
        chk("single_awready", {37'd0, dsp_AWREADY_o}, 40'b010);
        chk("single_wren", {39'd0, AW_fifo_order_wr_en_o}, 40'd1);
        chk("single_mstid", {38'd0, AW_mst_id_o}, 40'd1);
        chk("single_axlen", {37'd0, AW_AxLEN_o}, 40'd3);
        tick();
        clr_all();
        #1;
        chk("single_s_valid", {39'd0, s_AWVALID_o}, 40'd1);
        chk("single_s_awid", {33'd0, s_AWID_o}, 40'h25);
        chk("single_s_addr", {8'd0, s_AWADDR_o}, 40'h100);
        chk("single_s_len", {37'd0, s_AWLEN_o}, 40'd3);
        chk("idle_awready", {37'd0, dsp_AWREADY_o}, 40'd0);
        s_AWREADY_i = 1'b1;
        tick();
        chk("hs_drop_valid", {39'd0, s_AWVALID_o}, 40'd0);
        chk("hs_hold_addr", {8'd0, s_AWADDR_o}, 40'h100);

        // Stall: master 2 waits three cycles, then is taken as soon as stall drops.
        AW_stall_i = 1'b1;
        set_m(2, 1'b1, 1'b1, 5'd7, 32'h200, 3'd5);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_awready", {37'd0, dsp_AWREADY_o}, 40'd0);
            chk("stall_wren", {39'd0, AW_fifo_order_wr_en_o}, 40'd0);
            tick();
            chk("stall_s_valid", {39'd0, s_AWVALID_o}, 40'd0);
        end
        AW_stall_i = 1'b0;
        #1;
        chk("unstall_awready", {37'd0, dsp_AWREADY_o}, 40'b100);
        chk("unstall_wren", {39'd0, AW_fifo_order_wr_en_o}, 40'd1);
        chk("unstall_mstid", {38'd0, AW_mst_id_o}, 40'd2);
        chk("unstall_axlen", {37'd0, AW_AxLEN_o}, 40'd5);
        tick();
        clr_all();
        #1;
        chk("unstall_s_awid", {33'd0, s_AWID_o}, 40'h47);
        chk("unstall_s_addr", {8'd0, s_AWADDR_o}, 40'h200);
        tick();
        chk("unstall_drain", {39'd0, s_AWVALID_o}, 40'd0);

        // Slave select: master 0 valid but not targeting this slave; pointer is 0.
        set_m(0, 1'b1, 1'b0, 5'd1, 32'h10, 3'd1);
        set_m(2, 1'b1, 1'b1, 5'd9, 32'h300, 3'd2);
        #1;
        chk("sel_awready", {37'd0, dsp_AWREADY_o}, 40'b100);
        chk("sel_mstid", {38'd0, AW_mst_id_o}, 40'd2);
        tick();
        clr_all();
        #1;
        chk("sel_s_awid", {33'd0, s_AWID_o}, 40'h49);
        chk("sel_s_addr", {8'd0, s_AWADDR_o}, 40'h300);
        tick();

        // Fairness: all three request, slave always ready -> 0,1,2,0,1,2 back to back.
        for (int i = 0; i < 3; i++) begin
            set_m(i, 1'b1, 1'b1, 5'(i + 1), 32'h1000 + 32'(i * 16), 3'(i));
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_awready", {37'd0, dsp_AWREADY_o}, 40'(1 << (c % 3)));
            chk("rr_wren", {39'd0, AW_fifo_order_wr_en_o}, 40'd1);
            chk("rr_mstid", {38'd0, AW_mst_id_o}, 40'(c % 3));
            tick();
            chk("rr_s_valid", {39'd0, s_AWVALID_o}, 40'd1);
            chk("rr_s_addr", {8'd0, s_AWADDR_o}, 40'h1000 + 40'((c % 3) * 16));
        end

        // Backpressure: payload of master 2 frozen for four cycles with requests pending.
        s_AWREADY_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_awready", {37'd0, dsp_AWREADY_o}, 40'd0);
            chk("bp_wren", {39'd0, AW_fifo_order_wr_en_o}, 40'd0);
            tick();
            chk("bp_s_valid", {39'd0, s_AWVALID_o}, 40'd1);
            chk("bp_s_addr", {8'd0, s_AWADDR_o}, 40'h1020);
            chk("bp_s_awid", {33'd0, s_AWID_o}, 40'h43);
        end
        s_AWREADY_i = 1'b1;
        #1;
        chk("bp_release_awready", {37'd0, dsp_AWREADY_o}, 40'b001);
        chk("bp_release_wren", {39'd0, AW_fifo_order_wr_en_o}, 40'd1);
        tick();
        chk("bp_release_s_addr", {8'd0, s_AWADDR_o}, 40'h1000);

        // Grant master 1 so the pointer sits at 2 while BUSY, then reset.
        #1;
        chk("pre_rst_mstid", {38'd0, AW_mst_id_o}, 40'd1);
        tick();
        ARESET_i = 1'b1;
        #1;
        chk("midrst_awready", {37'd0, dsp_AWREADY_o}, 40'd0);
        chk("midrst_wren", {39'd0, AW_fifo_order_wr_en_o}, 40'd0);
        tick();
        chk("midrst_s_valid", {39'd0, s_AWVALID_o}, 40'd0);
        chk("midrst_s_addr", {8'd0, s_AWADDR_o}, 40'd0);
        chk("midrst_s_awid", {33'd0, s_AWID_o}, 40'd0);
        ARESET_i = 1'b0;
        #1;
        chk("post_rst_awready", {37'd0, dsp_AWREADY_o}, 40'b001);
        chk("post_rst_mstid", {38'd0, AW_mst_id_o}, 40'd0);
        tick();
        chk("post_rst_s_addr", {8'd0, s_AWADDR_o}, 40'h1000);
        chk("post_rst_s_awid", {33'd0, s_AWID_o}, 40'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
